midi_game_sched: RTL and testbench

// - Full MIDI byte-stream parser and control scheduler between the MIDI UART receiver and the VGA game logic.
// - Handles running status, real-time and SysEx bytes, and Note On/Off/CC on one channel.
// - Tracks slider (CC) value and left/right key hold state; schedules paddle step pulses with auto-repeat.

---
 rtl/midi_pkg.sv | 22 ++
 rtl/midi_repeat_timer.sv | 37 +++
 rtl/midi_game_sched.sv | 133 +++++++++++++
 tb/tb_midi_game_sched.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants and parser state encoding.
package midi_pkg;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_CC       = 4'hB;

  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  localparam logic [1:0] P_IDLE  = 2'd0;
  localparam logic [1:0] P_D1    = 2'd1;
  localparam logic [1:0] P_D2    = 2'd2;
  localparam logic [1:0] P_SYSEX = 2'd3;

  // True for the channel-voice statuses this block acts on.
  function automatic logic is_voice(input logic [7:0] b);
    return (b[7:4] == ST_NOTE_OFF) || (b[7:4] == ST_NOTE_ON) || (b[7:4] == ST_CC);
  endfunction

endpackage

// File: rtl/midi_repeat_timer.sv
// Per-direction step scheduler: step on press, then every REPEAT_DIV cycles while held.
module midi_repeat_timer #(
  parameter int REPEAT_DIV = 15000
) (
  input  logic clk,
  input  logic rst,
  input  logic press,
  input  logic held,
  input  logic freeze,
  output logic step
);

  localparam int CW = $clog2(REPEAT_DIV);

  logic [CW-1:0] cnt;

  // Freeze and release both park the counter at 0, so leaving freeze restarts the full period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      step <= 1'b0;
    end else if (freeze || !held) begin
      cnt  <= '0;
      step <= 1'b0;
    end else if (press) begin
      cnt  <= '0;
      step <= 1'b1;
    end else if (cnt == CW'(REPEAT_DIV - 1)) begin
      cnt  <= '0;
      step <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      step <= 1'b0;
    end
  end

endmodule

// File: rtl/midi_game_sched.sv
// MIDI byte-stream parser feeding slider value, key hold state and paddle step pulses.
module midi_game_sched
  import midi_pkg::*;
#(
  parameter logic [3:0] CHAN       = 4'h0,
  parameter logic [6:0] CC_SLIDER  = 7'h4A,
  parameter logic [6:0] NOTE_LEFT  = 7'h53,
  parameter logic [6:0] NOTE_RIGHT = 7'h54,
  parameter int         REPEAT_DIV = 15000
) (
  input  logic       clk500kHz,
  input  logic       RST,
  input  logic       MIDI_RDY,
  input  logic [7:0] MIDI_BYTE,
  output logic [6:0] VALUE,
  output logic [7:0] CTRLNUM,
  output logic       EVT,
  output logic       LEFT_HELD,
  output logic       RIGHT_HELD,
  output logic       STEP_L,
  output logic       STEP_R
);

  logic [1:0] state, state_n;
  logic [7:0] status, status_n;
  logic [6:0] key, key_n;
  logic [6:0] value_n;
  logic [7:0] ctrl_n;
  logic       evt_n, held_l_n, held_r_n, note_on;
  logic       freeze;

  // Next-state of parser and event outputs for the byte presented this cycle.
  always_comb begin
    state_n  = state;
    status_n = status;
    key_n    = key;
    value_n  = VALUE;
    ctrl_n   = CTRLNUM;
    evt_n    = 1'b0;
    held_l_n = LEFT_HELD;
    held_r_n = RIGHT_HELD;
    note_on  = (status[7:4] == ST_NOTE_ON) && (MIDI_BYTE[6:0] != 7'd0);
    if (MIDI_RDY && (MIDI_BYTE < RT_MIN)) begin
      if (MIDI_BYTE[7]) begin
        if ((state == P_SYSEX) && (MIDI_BYTE == SYSEX_END)) begin
          state_n = P_IDLE;
        end else if (is_voice(MIDI_BYTE)) begin
          status_n = MIDI_BYTE;
          state_n  = P_D1;
        end else if (MIDI_BYTE == SYSEX_START) begin
          status_n = '0;
          state_n  = P_SYSEX;
        end else begin
          status_n = '0;
          state_n  = P_IDLE;
        end
      end else begin
        case (state)
          P_D1: begin
            key_n   = MIDI_BYTE[6:0];
            state_n = P_D2;
          end
          P_D2: begin
            state_n = P_D1;
            if (status[3:0] == CHAN) begin
              if (status[7:4] == ST_CC) begin
                if (key == CC_SLIDER) begin
                  value_n = MIDI_BYTE[6:0];
                  ctrl_n  = {1'b0, key};
                  evt_n   = 1'b1;
                end
              end else if (key == NOTE_LEFT) begin
                held_l_n = note_on;
                ctrl_n   = {1'b0, key};
                evt_n    = 1'b1;
              end else if (key == NOTE_RIGHT) begin
                held_r_n = note_on;
                ctrl_n   = {1'b0, key};
                evt_n    = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Parser and output registers.
  always_ff @(posedge clk500kHz) begin
    if (RST) begin
      state      <= P_IDLE;
      status     <= '0;
      key        <= '0;
      VALUE      <= '0;
      CTRLNUM    <= '0;
      EVT        <= 1'b0;
      LEFT_HELD  <= 1'b0;
      RIGHT_HELD <= 1'b0;
    end else begin
      state      <= state_n;
      status     <= status_n;
      key        <= key_n;
      VALUE      <= value_n;
      CTRLNUM    <= ctrl_n;
      EVT        <= evt_n;
      LEFT_HELD  <= held_l_n;
      RIGHT_HELD <= held_r_n;
    end
  end

  // Frozen on the edge both become held and on the edge one leaves, so the survivor restarts from 0.
  assign freeze = (LEFT_HELD & RIGHT_HELD) | (held_l_n & held_r_n);

  midi_repeat_timer #(.REPEAT_DIV(REPEAT_DIV)) u_rep_l (
    .clk    (clk500kHz),
    .rst    (RST),
    .press  (held_l_n & ~LEFT_HELD),
    .held   (held_l_n),
    .freeze (freeze),
    .step   (STEP_L)
  );

  midi_repeat_timer #(.REPEAT_DIV(REPEAT_DIV)) u_rep_r (
    .clk    (clk500kHz),
    .rst    (RST),
    .press  (held_r_n & ~RIGHT_HELD),
    .held   (held_r_n),
    .freeze (freeze),
    .step   (STEP_R)
  );

endmodule

// File: tb/tb_midi_game_sched.sv
// Directed bench for midi_game_sched: byte-vector table plus repeat-timing sequences.
module tb_midi_game_sched;

  logic       clk = 1'b0;
  logic       RST;
  logic       MIDI_RDY;
  logic [7:0] MIDI_BYTE;
  logic [6:0] VALUE;
  logic [7:0] CTRLNUM;
  logic       EVT, LEFT_HELD, RIGHT_HELD, STEP_L, STEP_R;

  int errors = 0;
  int checks = 0;

  midi_game_sched #(.REPEAT_DIV(4)) dut (
    .clk500kHz  (clk),
    .RST        (RST),
    .MIDI_RDY   (MIDI_RDY),
    .MIDI_BYTE  (MIDI_BYTE),
    .VALUE      (VALUE),
    .CTRLNUM    (CTRLNUM),
    .EVT        (EVT),
    .LEFT_HELD  (LEFT_HELD),
    .RIGHT_HELD (RIGHT_HELD),
    .STEP_L     (STEP_L),
    .STEP_R     (STEP_R)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       evt;
    logic [6:0] val;
    logic [7:0] ctrl;
    logic       l, r, sl, sr;
    logic       dc;   // skip EVT/CTRLNUM for this row
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [7:0] b, input logic evt, input logic [6:0] val,
                     input logic [7:0] ctrl, input logic l, input logic r,
                     input logic sl, input logic sr, input logic dc);
    vec_t v;
    v.b = b; v.evt = evt; v.val = val; v.ctrl = ctrl;
    v.l = l; v.r = r; v.sl = sl; v.sr = sr; v.dc = dc;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    MIDI_RDY  = 1'b1;
    MIDI_BYTE = b;
    @(posedge clk); #1;
    MIDI_RDY  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  // STEP_L and STEP_R must never be high together.
  always @(negedge clk) begin
    if (!RST) begin
      checks++;
      if (STEP_L && STEP_R) begin
        errors++;
        $display("FAIL step_exclusive: got STEP_L=1 STEP_R=1 expected not both");
      end
    end
  end

  logic [7:0] pat_r [8];
  logic [7:0] pat_l [8];

  initial begin
    RST = 1'b1; MIDI_RDY = 1'b0; MIDI_BYTE = 8'h00;
    repeat (2) @(posedge clk);
    #1 RST = 1'b0;

    chk("rst VALUE", VALUE, 0);   chk("rst CTRLNUM", CTRLNUM, 0);
    chk("rst EVT", EVT, 0);       chk("rst LEFT", LEFT_HELD, 0);
    chk("rst RIGHT", RIGHT_HELD, 0);
    chk("rst STEP_L", STEP_L, 0); chk("rst STEP_R", STEP_R, 0);

    // Reset mid-message, with reset winning over a concurrent byte.
    send(8'h90); send(8'h53);
    RST = 1'b1; MIDI_RDY = 1'b1; MIDI_BYTE = 8'h7F;
    @(posedge clk); #1;
    RST = 1'b0; MIDI_RDY = 1'b0;
    chk("rstmid EVT0", EVT, 0); chk("rstmid LEFT0", LEFT_HELD, 0);
    send(8'h7F);
    chk("rstmid EVT", EVT, 0); chk("rstmid LEFT", LEFT_HELD, 0);
    chk("rstmid STEP_L", STEP_L, 0);

    //   byte   evt val    ctrl   l r sl sr dc
    add(8'h90, 0, 7'h00, 8'h00, 0,0,0,0, 0);
    add(8'h53, 0, 7'h00, 8'h00, 0,0,0,0, 0);
    add(8'h40, 1, 7'h00, 8'h53, 1,0,1,0, 0);
    add(8'h80, 0, 7'h00, 8'h53, 1,0,0,0, 0);
    add(8'h53, 0, 7'h00, 8'h53, 1,0,0,0, 0);
    add(8'h00, 1, 7'h00, 8'h53, 0,0,0,0, 0);
    add(8'hB0, 0, 7'h00, 8'h53, 0,0,0,0, 0);
    add(8'h4A, 0, 7'h00, 8'h53, 0,0,0,0, 0);
    add(8'h10, 1, 7'h10, 8'h4A, 0,0,0,0, 0);
    add(8'h4A, 0, 7'h10, 8'h4A, 0,0,0,0, 0);
    add(8'h20, 1, 7'h20, 8'h4A, 0,0,0,0, 0);
    add(8'h90, 0, 7'h20, 8'h4A, 0,0,0,0, 0);
    add(8'h54, 0, 7'h20, 8'h4A, 0,0,0,0, 0);
    add(8'h00, 0, 7'h20, 8'h00, 0,0,0,0, 1);
    add(8'hB0, 0, 7'h20, 8'h00, 0,0,0,0, 1);
    add(8'hF8, 0, 7'h20, 8'h00, 0,0,0,0, 1);
    add(8'h4A, 0, 7'h20, 8'h00, 0,0,0,0, 1);
    add(8'hFE, 0, 7'h20, 8'h00, 0,0,0,0, 1);
    add(8'h33, 1, 7'h33, 8'h4A, 0,0,0,0, 0);
    add(8'hF0, 0, 7'h33, 8'h4A, 0,0,0,0, 0);
    add(8'h4A, 0, 7'h33, 8'h4A, 0,0,0,0, 0);
    add(8'h7F, 0, 7'h33, 8'h4A, 0,0,0,0, 0);
    add(8'hF7, 0, 7'h33, 8'h4A, 0,0,0,0, 0);
    add(8'h33, 0, 7'h33, 8'h4A, 0,0,0,0, 0);
    add(8'hB1, 0, 7'h33, 8'h4A, 0,0,0,0, 0);
    add(8'h4A, 0, 7'h33, 8'h4A, 0,0,0,0, 0);
    add(8'h05, 0, 7'h33, 8'h4A, 0,0,0,0, 0);
    add(8'hB0, 0, 7'h33, 8'h4A, 0,0,0,0, 0);
    add(8'h4A, 0, 7'h33, 8'h4A, 0,0,0,0, 0);
    add(8'hF8, 0, 7'h33, 8'h4A, 0,0,0,0, 0);
    add(8'h44, 1, 7'h44, 8'h4A, 0,0,0,0, 0);
    add(8'h90, 0, 7'h44, 8'h4A, 0,0,0,0, 0);
    add(8'h53, 0, 7'h44, 8'h4A, 0,0,0,0, 0);
    add(8'hB0, 0, 7'h44, 8'h4A, 0,0,0,0, 0);
    add(8'h4A, 0, 7'h44, 8'h4A, 0,0,0,0, 0);
    add(8'h11, 1, 7'h11, 8'h4A, 0,0,0,0, 0);
    add(8'h90, 0, 7'h11, 8'h4A, 0,0,0,0, 0);
    add(8'h53, 0, 7'h11, 8'h4A, 0,0,0,0, 0);
    add(8'hF6, 0, 7'h11, 8'h4A, 0,0,0,0, 0);
    add(8'h40, 0, 7'h11, 8'h4A, 0,0,0,0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      send(tv[i].b);
      if (!tv[i].dc) begin
        chk($sformatf("vec%0d EVT", i), EVT, tv[i].evt);
        chk($sformatf("vec%0d CTRLNUM", i), CTRLNUM, tv[i].ctrl);
      end
      chk($sformatf("vec%0d VALUE", i), VALUE, tv[i].val);
      chk($sformatf("vec%0d LEFT", i), LEFT_HELD, tv[i].l);
      chk($sformatf("vec%0d RIGHT", i), RIGHT_HELD, tv[i].r);
      chk($sformatf("vec%0d STEP_L", i), STEP_L, tv[i].sl);
      chk($sformatf("vec%0d STEP_R", i), STEP_R, tv[i].sr);
    end

    // Hold right: step at press, then every 4 cycles.
    pat_r = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    send(8'h90); send(8'h54); send(8'h7F);
    chk("rep press RIGHT", RIGHT_HELD, 1);
    chk("rep press STEP_R", STEP_R, 1);
    for (int i = 0; i < 8; i++) begin
      idle();
      chk($sformatf("rep R cyc%0d STEP_R", i + 1), STEP_R, pat_r[i][0]);
    end
    idle();
    // Left press lands on the cycle right would have stepped; freeze suppresses both.
    send(8'h90); send(8'h53); send(8'h7F);
    chk("both LEFT", LEFT_HELD, 1);
    chk("both STEP_L", STEP_L, 0);
    chk("both STEP_R", STEP_R, 0);
    for (int i = 0; i < 8; i++) begin
      idle();
      chk($sformatf("both cyc%0d STEP_L", i + 1), STEP_L, 0);
      chk($sformatf("both cyc%0d STEP_R", i + 1), STEP_R, 0);
    end
    // Release right: left restarts, first step 4 cycles later.
    send(8'h80); send(8'h54); send(8'h00);
    chk("relR RIGHT", RIGHT_HELD, 0);
    chk("relR STEP_L", STEP_L, 0);
    pat_l = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    for (int i = 0; i < 8; i++) begin
      idle();
      chk($sformatf("relR cyc%0d STEP_L", i + 1), STEP_L, pat_l[i][0]);
      chk($sformatf("relR cyc%0d STEP_R", i + 1), STEP_R, 0);
    end
    // Release left: no step on the way out.
    send(8'h80); chk("relL a STEP_L", STEP_L, 0);
    send(8'h53); chk("relL b STEP_L", STEP_L, 0);
    send(8'h00); chk("relL c STEP_L", STEP_L, 0);
    chk("relL LEFT", LEFT_HELD, 0);
    idle(); idle(); idle(); idle();
    chk("relL after STEP_L", STEP_L, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
